utc_time_keeper: RTL and testbench
==================================

Name: utc_time_keeper

Overview:
- Sits directly downstream of the Thunderbolt TSIP receiver.
- Consumes the one-cycle packet-valid strobe and the seven UTC byte fields, range-checks them, and loads them into a local calendar.
- Advances the calendar on each GPS PPS rising edge, or on an internal 1 s timeout when PPS is missing.
- Provides a continuous, validated time-of-day to the pulse generators and the register map, with holdover and sync-loss status.

Parameters:
c_CLKS_PER_SEC, 10000000, i_clk cycles per nominal second (10 MHz system clock)
c_PPS_TIMEOUT, 10500000, cycles without a PPS edge before an internal tick is substituted
c_HOLDOVER_SEC, 5, consecutive ticks without an accepted packet before o_sync_lost asserts

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-low
i_pps  in  1  raw PPS from GPS (asynchronous)
i_thunder_packet_dv  in  1  one-cycle strobe; fields below valid in this cycle
i_thunder_year_h  in  8  year high byte
i_thunder_year_l  in  8  year low byte
i_thunder_month  in  8  month, 1..12
i_thunder_day  in  8  day, 1..31
i_thunder_hour  in  8  hour, 0..23
i_thunder_minutes  in  8  minute, 0..59
i_thunder_seconds  in  8  second, 0..59
o_year  out  16  current year
o_month  out  8  current month
o_day  out  8  current day
o_hour  out  8  current hour
o_minutes  out  8  current minute
o_seconds  out  8  current second
o_tick  out  1  one-cycle pulse, same cycle the time registers change due to a tick
o_time_valid  out  1  calendar has been loaded by at least one accepted packet
o_sync_lost  out  1  holdover exceeded, or ticks are currently internally generated
o_pkt_reject  out  1  one-cycle pulse on a rejected packet

Behaviour:
- Reset (i_rst low, async):
  - calendar = 2000-01-01 00:00:00; all status outputs 0.
  - PPS synchroniser, timeout counter and holdover counter cleared.
  - Deassertion is synchronised internally.
- PPS input path:
  - 2-FF synchroniser plus edge detect; a rising edge yields pps_evt one cycle after the second flop.
  - Total latency is 3 cycles from the i_pps edge.
- Timeout counter:
  - Cleared on pps_evt; increments otherwise.
  - Reaching c_PPS_TIMEOUT-1 yields int_evt and reloads the counter to c_PPS_TIMEOUT-c_CLKS_PER_SEC, so subsequent internal ticks fall every c_CLKS_PER_SEC cycles.
- Tick and internal mode:
  - tick = pps_evt | int_evt.
  - int_mode sets on int_evt and clears on pps_evt.
- Packet validation (combinational, same cycle as dv). Accept only if all hold:
  - year = {h,l} in 2000..2099;
  - month in 1..12;
  - day in 1..days_in_month;
  - hour ≤ 23, minutes ≤ 59, seconds ≤ 59.
  - days_in_month: Feb is 29 if year[1:0]==0, else 28; Apr/Jun/Sep/Nov are 30; the rest are 31.
- Accepted packet:
  - Calendar loads the fields on the next edge.
  - o_time_valid is set and stays set until reset.
  - Holdover counter cleared.
  - Packet time labels the PPS already elapsed, so there is no +1 adjustment.
- Rejected packet:
  - o_pkt_reject pulses for 1 cycle.
  - Calendar and counters are unchanged.
- Tick alone (no dv):
  - Seconds increment, with cascading carries:
    - sec 59 -> 0, min+1;
    - min 59 -> 0, hour+1;
    - hour 23 -> 0, day+1;
    - day = days_in_month -> 1, month+1;
    - month 12 -> 1, year+1.
  - Year 2099 wraps to 2000.
  - o_tick pulses in the same cycle the registers update.
  - Holdover counter increments, saturating at c_HOLDOVER_SEC.
- Tick and accepted dv in the same cycle:
  - Load the packet fields, then apply one increment (result = packet+1 s).
  - Holdover counter = 0; o_tick pulses.
- Tick and rejected dv in the same cycle: normal increment; o_pkt_reject pulses.
- o_sync_lost = (holdover counter == c_HOLDOVER_SEC) | int_mode. Registered.
- Ticks before the first accepted packet still advance the default calendar, with o_time_valid = 0.
- No leap-second support. A seconds field of 60 is rejected.

Test Plan:
1. Load, then PPS: dv with 2024-02-28 23:59:59, then PPS → 2024-02-29 00:00:00; o_tick 1 cycle; o_time_valid=1.
2. Non-leap rollover: load 2023-12-31 23:59:59, PPS → 2024-01-01 00:00:00. Load 2023-02-28 23:59:59, PPS → 2023-03-01.
3. Rejects: packets with month=13, day=31 in April, hour=24, seconds=60, year 1999 → o_pkt_reject pulses each time; calendar unchanged.
4. Simultaneous events: dv (12:00:00) in the same cycle as pps_evt → 12:00:01; holdover=0.
5. Holdover and timeout:
   - 5 PPS with no packets → o_sync_lost=1 at the 5th tick.
   - Stop PPS → int_evt after 10500000 cycles, then every 10000000; o_sync_lost stays 1.
   - Restore PPS and send an accepted packet → o_sync_lost=0.
6. Reset mid-operation: assert i_rst low asynchronously mid-second → outputs immediately 2000-01-01 00:00:00, all flags 0; a PPS within 2 cycles of release is ignored.

Source files
------------

// File: rtl/utc_time_keeper.sv
// utc_time_keeper: UTC calendar loaded from TSIP packets and
// advanced by GPS PPS, with an internal 1 s fallback tick.
module utc_time_keeper #(
  parameter int c_CLKS_PER_SEC = 10000000,
  parameter int c_PPS_TIMEOUT  = 10500000,
  parameter int c_HOLDOVER_SEC = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pps,
  input  logic        i_thunder_packet_dv,
  input  logic [7:0]  i_thunder_year_h,
  input  logic [7:0]  i_thunder_year_l,
  input  logic [7:0]  i_thunder_month,
  input  logic [7:0]  i_thunder_day,
  input  logic [7:0]  i_thunder_hour,
  input  logic [7:0]  i_thunder_minutes,
  input  logic [7:0]  i_thunder_seconds,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic        o_tick,
  output logic        o_time_valid,
  output logic        o_sync_lost,
  output logic        o_pkt_reject
);

  localparam int c_TW = $clog2(c_PPS_TIMEOUT + 1);
  localparam int c_HW = $clog2(c_HOLDOVER_SEC + 1);

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } cal_t;

  localparam cal_t c_RST_CAL = '{
    year: 16'd2000, month: 8'd1, day: 8'd1,
    hour: 8'd0, minutes: 8'd0, seconds: 8'd0
  };

  function automatic logic [7:0] dim(
    input logic [15:0] y,
    input logic [7:0]  m
  );
    logic [7:0] d;
    case (m)
      8'd2:    d = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      8'd4,
      8'd6,
      8'd9,
      8'd11:   d = 8'd30;
      default: d = 8'd31;
    endcase
    return d;
  endfunction

  function automatic cal_t cal_inc(input cal_t c);
    cal_t n;
    n = c;
    if (c.seconds != 8'd59) begin
      n.seconds = c.seconds + 8'd1;
    end else begin
      n.seconds = 8'd0;
      if (c.minutes != 8'd59) begin
        n.minutes = c.minutes + 8'd1;
      end else begin
        n.minutes = 8'd0;
        if (c.hour != 8'd23) begin
          n.hour = c.hour + 8'd1;
        end else begin
          n.hour = 8'd0;
          if (c.day < dim(c.year, c.month)) begin
            n.day = c.day + 8'd1;
          end else begin
            n.day = 8'd1;
            if (c.month != 8'd12) begin
              n.month = c.month + 8'd1;
            end else begin
              n.month = 8'd1;
              n.year  = (c.year == 16'd2099) ?
                        16'd2000 : c.year + 16'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  logic [1:0]      rst_q;
  logic            rst_n;
  logic [2:0]      pps_q;
  logic            pps_evt;
  logic [c_TW-1:0] to_cnt;
  logic            int_evt;
  logic            tick;
  cal_t            pkt;
  logic            pkt_ok;
  logic            pkt_acc;
  logic            pkt_rej;
  cal_t            cal;
  cal_t            cal_base;
  cal_t            cal_nxt;
  logic [c_HW-1:0] hold_cnt;
  logic [c_HW-1:0] hold_nxt;
  logic            int_mode;
  logic            int_nxt;

  // Reset asserts at once, releases two clocks after i_rst rises
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  // PPS sync chain preset high: a PPS already high at release is no edge
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_q   <= 3'b111;
      pps_evt <= 1'b0;
    end else begin
      pps_q   <= {pps_q[1:0], i_pps};
      pps_evt <= pps_q[1] & ~pps_q[2];
    end
  end

  assign int_evt = ~pps_evt &
                   (to_cnt == c_TW'(c_PPS_TIMEOUT - 1));
  assign tick    = pps_evt | int_evt;

  // Missing-PPS watchdog; reload keeps later internal ticks 1 s apart
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)       to_cnt <= '0;
    else if (pps_evt) to_cnt <= '0;
    else if (int_evt) to_cnt <= c_TW'(c_PPS_TIMEOUT - c_CLKS_PER_SEC);
    else              to_cnt <= to_cnt + c_TW'(1);
  end

  assign pkt = {i_thunder_year_h, i_thunder_year_l,
                i_thunder_month, i_thunder_day,
                i_thunder_hour, i_thunder_minutes,
                i_thunder_seconds};

  assign pkt_ok =
    (pkt.year >= 16'd2000) && (pkt.year <= 16'd2099) &&
    (pkt.month >= 8'd1) && (pkt.month <= 8'd12) &&
    (pkt.day >= 8'd1) &&
    (pkt.day <= dim(pkt.year, pkt.month)) &&
    (pkt.hour <= 8'd23) &&
    (pkt.minutes <= 8'd59) &&
    (pkt.seconds <= 8'd59);

  assign pkt_acc = i_thunder_packet_dv & pkt_ok;
  assign pkt_rej = i_thunder_packet_dv & ~pkt_ok;

  // Next calendar: packet load first, then one tick on top
  always_comb begin
    cal_base = pkt_acc ? pkt : cal;
    cal_nxt  = tick ? cal_inc(cal_base) : cal_base;
    hold_nxt = hold_cnt;
    if (pkt_acc)
      hold_nxt = '0;
    else if (tick && (hold_cnt != c_HW'(c_HOLDOVER_SEC)))
      hold_nxt = hold_cnt + c_HW'(1);
    int_nxt = int_mode;
    if (pps_evt)      int_nxt = 1'b0;
    else if (int_evt) int_nxt = 1'b1;
  end

  // Calendar, holdover and status registers
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cal          <= c_RST_CAL;
      hold_cnt     <= '0;
      int_mode     <= 1'b0;
      o_tick       <= 1'b0;
      o_time_valid <= 1'b0;
      o_sync_lost  <= 1'b0;
      o_pkt_reject <= 1'b0;
    end else begin
      cal          <= cal_nxt;
      hold_cnt     <= hold_nxt;
      int_mode     <= int_nxt;
      o_tick       <= tick;
      o_time_valid <= o_time_valid | pkt_acc;
      o_sync_lost  <= (hold_nxt == c_HW'(c_HOLDOVER_SEC)) | int_nxt;
      o_pkt_reject <= pkt_rej;
    end
  end

  assign o_year    = cal.year;
  assign o_month   = cal.month;
  assign o_day     = cal.day;
  assign o_hour    = cal.hour;
  assign o_minutes = cal.minutes;
  assign o_seconds = cal.seconds;

endmodule

// File: tb/tb_utc_time_keeper.sv
// tb_utc_time_keeper: scoreboard bench for utc_time_keeper,
// reference model keeps time as seconds since 2000-01-01.
module tb_utc_time_keeper;

  localparam int CPS  = 40;
  localparam int TO   = 60;
  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  yh = '0, yl = '0, mo = '0, dy = '0;
  logic [7:0]  hr = '0, mi = '0, se = '0;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
  logic        o_tick, o_time_valid, o_sync_lost, o_pkt_reject;

  utc_time_keeper #(
    .c_CLKS_PER_SEC(CPS),
    .c_PPS_TIMEOUT(TO),
    .c_HOLDOVER_SEC(HOLD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_pps(pps),
    .i_thunder_packet_dv(dv),
    .i_thunder_year_h(yh),
    .i_thunder_year_l(yl),
    .i_thunder_month(mo),
    .i_thunder_day(dy),
    .i_thunder_hour(hr),
    .i_thunder_minutes(mi),
    .i_thunder_seconds(se),
    .o_year(o_year),
    .o_month(o_month),
    .o_day(o_day),
    .o_hour(o_hour),
    .o_minutes(o_minutes),
    .o_seconds(o_seconds),
    .o_tick(o_tick),
    .o_time_valid(o_time_valid),
    .o_sync_lost(o_sync_lost),
    .o_pkt_reject(o_pkt_reject)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int y; int mo; int d; int h; int mi; int s;
  } tm_t;

  typedef struct {
    bit  tick; bit rej; tm_t t;
    bit  valid; bit lost; int gap;
  } exp_t;

  exp_t   sbq[$];
  int     npass = 0;
  int     ntot = 0;
  longint span;
  longint m_secs = 0;
  bit     m_valid = 0;
  int     m_hold = 0;
  bit     m_int = 0;
  int     last_tick = 0;

  function automatic bit leap(int y);
    return (y % 4) == 0;
  endfunction

  function automatic int mdays(int y, int m);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && leap(y)) return 29;
    return t[m-1];
  endfunction

  function automatic longint to_secs(tm_t t);
    longint days = 0;
    for (int y = 2000; y < t.y; y++) days += leap(y) ? 366 : 365;
    for (int m = 1; m < t.mo; m++) days += mdays(t.y, m);
    days += t.d - 1;
    return days * 86400 + t.h * 3600 + t.mi * 60 + t.s;
  endfunction

  function automatic tm_t from_secs(longint s);
    tm_t    t;
    longint d;
    d    = s / 86400;
    s    = s % 86400;
    t.h  = int'(s / 3600);
    t.mi = int'((s % 3600) / 60);
    t.s  = int'(s % 60);
    t.y  = 2000;
    while (d >= (leap(t.y) ? 366 : 365)) begin
      d -= leap(t.y) ? 366 : 365;
      t.y++;
    end
    t.mo = 1;
    while (d >= mdays(t.y, t.mo)) begin
      d -= mdays(t.y, t.mo);
      t.mo++;
    end
    t.d = int'(d) + 1;
    return t;
  endfunction

  function automatic bit pkt_valid(tm_t t);
    if (t.y < 2000 || t.y > 2099) return 0;
    if (t.mo < 1 || t.mo > 12) return 0;
    if (t.d < 1 || t.d > mdays(t.y, t.mo)) return 0;
    return (t.h <= 23) && (t.mi <= 59) && (t.s <= 59);
  endfunction

  function automatic tm_t mk(int y, int m, int d, int h, int n, int s);
    tm_t t;
    t.y = y; t.mo = m; t.d = d; t.h = h; t.mi = n; t.s = s;
    return t;
  endfunction

  function automatic exp_t snap(bit tk, bit rj, int gap);
    exp_t e;
    e.tick  = tk;
    e.rej   = rj;
    e.t     = from_secs(m_secs);
    e.valid = m_valid;
    e.lost  = (m_hold == HOLD) || m_int;
    e.gap   = gap;
    return e;
  endfunction

  function automatic string fmt(tm_t t);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d",
                     t.y, t.mo, t.d, t.h, t.mi, t.s);
  endfunction

  function automatic tm_t dut_tm();
    return mk(int'(o_year), int'(o_month), int'(o_day),
              int'(o_hour), int'(o_minutes), int'(o_seconds));
  endfunction

  task automatic chk(input bit ok, input string nm, input string det);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: %s", nm, det);
  endtask

  task automatic model_sec(input bit internal);
    m_secs = (m_secs + 1) % span;
    m_int  = internal;
  endtask

  task automatic hold_inc();
    if (m_hold < HOLD) m_hold++;
  endtask

  // Scoreboard monitor: one expected entry per reported event
  always @(negedge clk) begin
    if (rst_n && (o_tick || o_pkt_reject)) begin
      if (sbq.size() == 0) begin
        chk(0, "unexpected_event",
            $sformatf("tick=%0b rej=%0b time=%s at cyc %0d",
                      o_tick, o_pkt_reject, fmt(dut_tm()), cyc));
      end else begin
        exp_t e;
        tm_t  g;
        e = sbq.pop_front();
        g = dut_tm();
        chk(o_tick == e.tick && o_pkt_reject == e.rej &&
            g == e.t && o_time_valid == e.valid &&
            o_sync_lost == e.lost, "event",
            $sformatf("got t=%0b r=%0b %s v=%0b l=%0b want t=%0b r=%0b %s v=%0b l=%0b",
                      o_tick, o_pkt_reject, fmt(g), o_time_valid,
                      o_sync_lost, e.tick, e.rej, fmt(e.t),
                      e.valid, e.lost));
        if (e.gap != 0)
          chk(cyc - last_tick == e.gap, "int_tick_gap",
              $sformatf("got %0d want %0d", cyc - last_tick, e.gap));
      end
      if (o_tick) last_tick = cyc;
    end
  end

  task automatic drive(input tm_t t);
    {yh, yl} = 16'(t.y);
    mo = 8'(t.mo);
    dy = 8'(t.d);
    hr = 8'(t.h);
    mi = 8'(t.mi);
    se = 8'(t.s);
  endtask

  // packet applied to model; with_tick means a PPS lands the same cycle
  task automatic model_pkt(input tm_t t, input bit with_tick);
    bit ok;
    ok = pkt_valid(t);
    if (ok) begin
      m_secs  = to_secs(t);
      m_valid = 1;
      m_hold  = 0;
    end
    if (with_tick) begin
      model_sec(0);
      if (!ok) hold_inc();
    end
    if (with_tick || !ok) sbq.push_back(snap(with_tick, !ok, 0));
  endtask

  task automatic send_pkt(input tm_t t);
    bit ok;
    ok = pkt_valid(t);
    @(negedge clk);
    drive(t);
    dv = 1;
    model_pkt(t, 0);
    @(negedge clk);
    dv = 0;
    #1;
    if (ok)
      chk(dut_tm() == from_secs(m_secs) && o_time_valid, "load",
          $sformatf("got %s v=%0b want %s", fmt(dut_tm()),
                    o_time_valid, fmt(from_secs(m_secs))));
  endtask

  // PPS pulse; optional packet arrives in the pps_evt cycle
  task automatic pps_pulse(input bit has_pkt, input tm_t t);
    @(negedge clk);
    pps = 1;
    if (!has_pkt) begin
      model_sec(0);
      hold_inc();
      sbq.push_back(snap(1, 0, 0));
    end
    repeat (3) @(negedge clk);
    if (has_pkt) begin
      drive(t);
      dv = 1;
      model_pkt(t, 1);
    end
    @(negedge clk);
    dv  = 0;
    pps = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk(sbq.size() == 0, "drain",
        $sformatf("%0d events still pending", sbq.size()));
    sbq.delete();
  endtask

  function automatic tm_t rnd_tm();
    tm_t t;
    t.y  = 2000 + int'($urandom_range(99));
    t.mo = 1 + int'($urandom_range(11));
    t.d  = 1 + int'($urandom_range(mdays(t.y, t.mo) - 1));
    t.h  = int'($urandom_range(23));
    t.mi = int'($urandom_range(59));
    t.s  = int'($urandom_range(59));
    if ($urandom_range(1) == 1) begin
      if ($urandom_range(2) == 0) t.mo = 12;
      t.d  = mdays(t.y, t.mo);
      t.h  = 23;
      t.mi = 59;
      t.s  = 59;
    end
    return t;
  endfunction

  function automatic tm_t corrupt(tm_t t);
    case ($urandom_range(5))
      0: t.y = ($urandom_range(1) == 1) ? 1999 : 2100;
      1: t.mo = ($urandom_range(1) == 1) ? 0 : 13 + int'($urandom_range(200));
      2: t.d = ($urandom_range(1) == 1) ? 0 :
               mdays(t.y, t.mo) + 1 + int'($urandom_range(3));
      3: t.h = 24 + int'($urandom_range(200));
      4: t.mi = 60 + int'($urandom_range(150));
      default: t.s = 60 + int'($urandom_range(150));
    endcase
    return t;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tm_t nop;
    nop  = mk(2000, 1, 1, 0, 0, 0);
    span = to_secs(mk(2100, 1, 1, 0, 0, 0));

    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    #1;
    chk(o_year == 16'd2000 && o_month == 8'd1 && o_day == 8'd1,
        "reset_date", fmt(dut_tm()));
    chk(o_hour == 0 && o_minutes == 0 && o_seconds == 0,
        "reset_time", fmt(dut_tm()));
    chk(!o_time_valid && !o_sync_lost, "reset_status",
        $sformatf("v=%0b l=%0b", o_time_valid, o_sync_lost));
    chk(!o_tick && !o_pkt_reject, "reset_pulses",
        $sformatf("t=%0b r=%0b", o_tick, o_pkt_reject));

    // leap day, year end, non-leap Feb, century wrap
    send_pkt(mk(2024, 2, 28, 23, 59, 59));  pps_pulse(0, nop);
    send_pkt(mk(2023, 12, 31, 23, 59, 59)); pps_pulse(0, nop);
    send_pkt(mk(2023, 2, 28, 23, 59, 59));  pps_pulse(0, nop);
    send_pkt(mk(2024, 12, 31, 23, 59, 59)); pps_pulse(0, nop);
    send_pkt(mk(2099, 12, 31, 23, 59, 59)); pps_pulse(0, nop);
    send_pkt(mk(2024, 4, 30, 23, 59, 58));  pps_pulse(0, nop);

    // rejects leave the calendar alone
    send_pkt(mk(2024, 13, 1, 0, 0, 0));
    send_pkt(mk(2024, 4, 31, 0, 0, 0));
    send_pkt(mk(2024, 5, 1, 24, 0, 0));
    send_pkt(mk(2024, 5, 1, 0, 0, 60));
    send_pkt(mk(1999, 5, 1, 0, 0, 0));
    send_pkt(mk(2023, 2, 29, 0, 0, 0));
    send_pkt(mk(2024, 5, 0, 0, 0, 0));
    pps_pulse(0, nop);

    // packet coincident with pps_evt
    pps_pulse(1, mk(2024, 6, 15, 12, 0, 0));
    pps_pulse(1, mk(2024, 6, 15, 12, 60, 0));

    // holdover then PPS loss
    send_pkt(mk(2030, 7, 4, 8, 0, 0));
    for (int k = 0; k < HOLD + 1; k++) pps_pulse(0, nop);
    for (int k = 0; k < 3; k++) begin
      model_sec(1);
      hold_inc();
      sbq.push_back(snap(1, 0, (k == 0) ? TO : CPS));
    end
    drain(TO + 3 * CPS);
    pps_pulse(1, mk(2031, 1, 1, 0, 0, 0));
    drain(10);

    for (int it = 0; it < 40; it++) begin
      tm_t t;
      t = rnd_tm();
      case ($urandom_range(2))
        0: send_pkt(t);
        1: send_pkt(corrupt(t));
        default: ;
      endcase
      t = rnd_tm();
      case ($urandom_range(3))
        0: pps_pulse(1, t);
        1: pps_pulse(1, corrupt(t));
        default: pps_pulse(0, nop);
      endcase
    end
    drain(10);

    // async reset mid-second, PPS right at release ignored
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk(o_year == 16'd2000 && o_month == 8'd1 && o_day == 8'd1 &&
        o_hour == 0 && o_minutes == 0 && o_seconds == 0,
        "async_rst_cal", fmt(dut_tm()));
    chk(!o_tick && !o_time_valid && !o_sync_lost && !o_pkt_reject,
        "async_rst_flags",
        $sformatf("t=%0b v=%0b l=%0b r=%0b", o_tick, o_time_valid,
                  o_sync_lost, o_pkt_reject));
    sbq.delete();
    m_secs = 0; m_valid = 0; m_hold = 0; m_int = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    pps   = 1;
    repeat (8) @(negedge clk);
    pps = 0;
    repeat (3) @(negedge clk);
    #1;
    chk(o_seconds == 0 && !o_tick, "pps_after_rst_ignored",
        fmt(dut_tm()));

    // unloaded calendar still advances
    pps_pulse(0, nop);
    pps_pulse(0, nop);
    drain(10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
